mem_lsu: RTL
============

# mem_lsu

Parametrised load/store memory stage for the five-stage pipeline, placed between EX and WB in place of the plain pass-through memory stage. Non-memory results are registered through in one cycle. Loads and stores run a req/ack transaction on the data-memory port with byte-lane selects and sign/zero extension, and any number of wait states. While a transaction is in flight the block stalls the upstream stages.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- REG_ADDR_W, 5, register-file address width
- DATA_W, 32, data width; fixed at 32 (4 byte lanes), elaboration error otherwise

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- valid_i  in  1  EX result valid
- wd_i  in  REG_ADDR_W  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  DATA_W  ALU result
- memop_i  in  4  memory op code (package enum)
- mem_addr_i  in  ADDR_W  effective address
- store_data_i  in  DATA_W  store source (rt)
- stallreq_o  out  1  hold EX/ID/IF this cycle
- valid_o, wd_o, wreg_o, wdata_o  out  1/REG_ADDR_W/1/DATA_W  registered result to WB
- dmem_req_o  out  1  request, held until ack
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  ADDR_W  address, low 2 bits forced 0
- dmem_sel_o  out  4  byte-lane enables
- dmem_wdata_o  out  DATA_W  store data, replicated to lanes
- dmem_rdata_i  in  DATA_W  load data, valid with ack
- dmem_ack_i  in  1  completion
- excpt_o  out  1  misaligned-access flag, aligned with valid_o
- badaddr_o  out  ADDR_W  faulting address

## Operation
- memop codes: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW. Little-endian lanes.
- States: IDLE, REQ.
- IDLE, valid_i=1, memop NONE: capture wd/wreg/wdata. valid_o=1 next cycle. No stall.
- IDLE, valid_i=1, memop load/store: latch address, op, wd, store data; stallreq_o=1; go to REQ.
- REQ: dmem_req_o=1 and bus fields stable until dmem_ack_i=1.
- On ack, load: select lane by addr[1:0] (byte) or addr[1] (half). LB/LH sign-extend; LBU/LHU zero-extend. Write wdata_o, wreg_o=1, wd_o = latched wd.
- On ack, store: wreg_o=0. In both cases valid_o=1 next cycle and return to IDLE.
- sel: SB = 1<<addr[1:0]; SH = addr[1] ? 1100 : 0011; SW/LW = 1111. Loads use the same sel. SB store data replicates its byte ×4; SH replicates its half ×2.
- stallreq_o = (IDLE & valid_i & memop≠NONE) | (REQ & ~dmem_ack_i).
- valid_i=0 in IDLE: valid_o=0 next cycle, other outputs hold.

## Timing
- Reset (rst=0, async): state IDLE. valid_o, wreg_o, wd_o, wdata_o, dmem_req_o, dmem_we_o, dmem_sel_o, dmem_addr_o, dmem_wdata_o, excpt_o, badaddr_o all 0. stallreq_o=0.
- Reset mid-REQ: dmem_req_o drops immediately. The transaction is abandoned and no valid_o is produced. A late ack after reset is ignored.
- Non-memory latency: 1 cycle.
- Memory latency: accept at T, req rises T+1, ack at T+k (k≥1), valid_o at T+k+1. The minimum is 2 cycles with zero wait states.
- Ack seen only in REQ. Ack in IDLE is ignored.
- valid_o is a single-cycle pulse per accepted instruction. Back-to-back non-memory ops give continuous valid_o.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0, issues no bus request and does not stall.
  - Next cycle: valid_o=1, wreg_o=0, excpt_o=1, badaddr_o=address.
- MEM_ALIGN_CHECK_EN undefined:
  - Low address bits beyond lane selection are ignored. LH at addr[0]=1 behaves as at addr[0]=0; LW/SW always use sel 1111.
  - excpt_o and badaddr_o are tied 0.

## Structure
- Shared package (define.v): memop encodings, state encodings, ZeroWord, NOPRegAddr.
- One sub-module: mem_lsu_align. It is combinational and produces the sel mask, store replication, and load lane extract/extend. It is shared by the store and load paths.

## Test plan
- Non-memory op wd=3, wdata=0x1234, wreg=1 → next cycle valid_o=1, wd_o=3, wdata_o=0x1234, no stall.
- LB at 0x1003, ack after 2 waits, rdata=0x80FF_FF00 → sel=1000, stall for 3 cycles, wdata_o=0xFFFF_FF80. LBU on the same access → 0x0000_0080.
- SH at 0x2002, data 0xABCD → sel=1100, we=1, wdata=0xABCD_ABCD, wreg_o=0 on valid_o.
- LW at 0x3001 with MEM_ALIGN_CHECK_EN → no dmem_req_o, excpt_o=1, badaddr_o=0x3001. Without the macro → access at 0x3000 with sel 1111.
- rst pulled low in REQ before ack → dmem_req_o=0 immediately, no valid_o. A following ack is ignored.
- Back-to-back LW (zero-wait) then non-memory op → valid_o at T+2 and T+3, stallreq_o high only in cycle T.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store memory stage: memop and FSM encodings,
// reset constants and small decode helpers.
package mem_lsu_pkg;

    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LBU  = 4'd2,
        MEMOP_LH   = 4'd3,
        MEMOP_LHU  = 4'd4,
        MEMOP_LW   = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } memop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

    // Codes outside the defined set are treated as plain pass-through results.
    function automatic logic is_mem(memop_e op);
        return op inside {MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW,
                          MEMOP_SB, MEMOP_SH, MEMOP_SW};
    endfunction

    function automatic logic is_store(memop_e op);
        return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW};
    endfunction

    function automatic logic misaligned(memop_e op, logic [1:0] addr_lo);
        case (op)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return addr_lo[0];
            MEMOP_LW, MEMOP_SW:            return addr_lo != 2'b00;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory req/ack bus between the load/store stage (master) and memory (slave).
interface mem_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        sel;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, sel, wdata, input rdata, ack);
    modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lsu_align.sv
// Byte-lane helper for the load/store stage: lane select mask, store-data
// replication and load lane extraction with sign/zero extension.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  memop_e      op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_ext;
    logic signed [31:0] half_ext;

    always_comb begin
        byte_s      = signed'(rdata_i[{addr_lo_i, 3'b000} +: 8]);
        half_s      = signed'(addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0]);
        byte_ext    = byte_s;
        half_ext    = half_s;
        sel_o       = 4'b0000;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        // Halfword lanes follow addr[1] only, so addr[0] never shifts a half.
        case (op_i)
            MEMOP_LB: begin
                sel_o       = 4'b0001 << addr_lo_i;
                load_data_o = byte_ext;
            end
            MEMOP_LBU: begin
                sel_o       = 4'b0001 << addr_lo_i;
                load_data_o = {24'h0, byte_s};
            end
            MEMOP_LH: begin
                sel_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                load_data_o = half_ext;
            end
            MEMOP_LHU: begin
                sel_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                load_data_o = {16'h0, half_s};
            end
            MEMOP_LW, MEMOP_SW: sel_o = 4'b1111;
            MEMOP_SB: begin
                sel_o   = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            MEMOP_SH: begin
                sel_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: sel_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store memory stage between EX and WB: pass-through for ALU results,
// req/ack data-memory transactions for loads/stores. Optional MEM_ALIGN_CHECK_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  memop_e                memop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     store_data_i,
    output logic                  stallreq_o,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    mem_lsu_if.master             dmem,
    output logic                  excpt_o,
    output logic [ADDR_W-1:0]     badaddr_o
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_lsu: DATA_W must be 32");
    end

    state_e                state_q, state_d;
    memop_e                op_q, op_d;
    logic [1:0]            lo_q, lo_d;
    logic [REG_ADDR_W-1:0] pend_wd_q, pend_wd_d;
    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] wd_out_q, wd_out_d;
    logic                  wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  excpt_q, excpt_d;
    logic [ADDR_W-1:0]     badaddr_q, badaddr_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     baddr_q, baddr_d;
    logic [3:0]            sel_q, sel_d;
    logic [DATA_W-1:0]     bwdata_q, bwdata_d;
    logic                  stall;
    logic                  mis;
    memop_e                align_op;
    logic [1:0]            align_lo;
    logic [3:0]            align_sel;
    logic [31:0]           align_wdata;
    logic [31:0]           align_load;

    // One lane unit serves both paths: inputs in IDLE, latched op in REQ.
    always_comb begin
        align_op = (state_q == ST_REQ) ? op_q : memop_i;
        align_lo = (state_q == ST_REQ) ? lo_q : mem_addr_i[1:0];
    end

    mem_lsu_align u_align (
        .op_i         (align_op),
        .addr_lo_i    (align_lo),
        .store_data_i (store_data_i),
        .rdata_i      (dmem.rdata),
        .sel_o        (align_sel),
        .wdata_o      (align_wdata),
        .load_data_o  (align_load)
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = misaligned(memop_i, mem_addr_i[1:0]);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        lo_d      = lo_q;
        pend_wd_d = pend_wd_q;
        valid_d   = 1'b0;
        wd_out_d  = wd_out_q;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        excpt_d   = excpt_q;
        badaddr_d = badaddr_q;
        req_d     = req_q;
        we_d      = we_q;
        baddr_d   = baddr_q;
        sel_d     = sel_q;
        bwdata_d  = bwdata_q;
        stall     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (!is_mem(memop_i)) begin
                        valid_d  = 1'b1;
                        wd_out_d = wd_i;
                        wreg_d   = wreg_i;
                        wdata_d  = wdata_i;
                        excpt_d  = 1'b0;
                    end else if (mis) begin
`ifdef MEM_ALIGN_CHECK_EN
                        valid_d   = 1'b1;
                        wd_out_d  = wd_i;
                        wreg_d    = 1'b0;
                        excpt_d   = 1'b1;
                        badaddr_d = mem_addr_i;
`endif
                    end else begin
                        state_d   = ST_REQ;
                        stall     = 1'b1;
                        op_d      = memop_i;
                        lo_d      = mem_addr_i[1:0];
                        pend_wd_d = wd_i;
                        req_d     = 1'b1;
                        we_d      = is_store(memop_i);
                        baddr_d   = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        sel_d     = align_sel;
                        bwdata_d  = align_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (dmem.ack) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    valid_d  = 1'b1;
                    wd_out_d = pend_wd_q;
                    excpt_d  = 1'b0;
                    if (is_store(op_q)) begin
                        wreg_d = 1'b0;
                    end else begin
                        wreg_d  = 1'b1;
                        wdata_d = align_load;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Async reset clears the bus request at once, abandoning any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= MEMOP_NONE;
            lo_q      <= 2'b00;
            pend_wd_q <= NOP_REG_ADDR;
            valid_q   <= 1'b0;
            wd_out_q  <= NOP_REG_ADDR;
            wreg_q    <= 1'b0;
            wdata_q   <= ZERO_WORD;
            excpt_q   <= 1'b0;
            badaddr_q <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            sel_q     <= 4'b0000;
            bwdata_q  <= ZERO_WORD;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            lo_q      <= lo_d;
            pend_wd_q <= pend_wd_d;
            valid_q   <= valid_d;
            wd_out_q  <= wd_out_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            excpt_q   <= excpt_d;
            badaddr_q <= badaddr_d;
            req_q     <= req_d;
            we_q      <= we_d;
            baddr_q   <= baddr_d;
            sel_q     <= sel_d;
            bwdata_q  <= bwdata_d;
        end
    end

    assign stallreq_o = stall;
    assign valid_o    = valid_q;
    assign wd_o       = wd_out_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;
    assign excpt_o    = excpt_q;
    assign badaddr_o  = badaddr_q;
    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = baddr_q;
    assign dmem.sel   = sel_q;
    assign dmem.wdata = bwdata_q;

endmodule
